// File: rtl/ibex_rf_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter.
//   RfAddrW       : register address width
//   rf_wr_entry_t : pending load-write tag (address + live flag). Data is stored
//                   beside it because its width is a parameter.
package ibex_rf_write_arbiter_pkg;

  localparam int unsigned RfAddrW = 5;

  typedef struct packed {
    logic [4:0] addr;
    logic       live;
  } rf_wr_entry_t;

endpackage

// File: rtl/ibex_rf_wr_fifo.sv
// In-order pending buffer for load writebacks that lost the write port.
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   push_i/push_addr_i/_data_i enqueue a load write
//   pop_i                      dequeue the head
//   kill_i/kill_addr_i         clear live on every entry matching the address
//   empty_o, full_o            occupancy flags
//   head_o, head_data_o        oldest entry
//   raddr_{a,b}_i              read addresses to look up
//   fwd_{a,b}_hit_o/_data_o    youngest live match, '0 data on miss
module ibex_rf_wr_fifo
  import ibex_rf_write_arbiter_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 push_i,
  input  logic [RfAddrW-1:0]   push_addr_i,
  input  logic [DataWidth-1:0] push_data_i,
  input  logic                 pop_i,
  input  logic                 kill_i,
  input  logic [RfAddrW-1:0]   kill_addr_i,
  output logic                 empty_o,
  output logic                 full_o,
  output rf_wr_entry_t         head_o,
  output logic [DataWidth-1:0] head_data_o,
  input  logic [RfAddrW-1:0]   raddr_a_i,
  input  logic [RfAddrW-1:0]   raddr_b_i,
  output logic                 fwd_a_hit_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  output logic                 fwd_b_hit_o,
  output logic [DataWidth-1:0] fwd_b_data_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  typedef logic [PtrW-1:0] ptr_t;

  ptr_t                 rd_ptr_q, rd_ptr_d;
  ptr_t                 wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  rf_wr_entry_t         entry_q [Depth];
  rf_wr_entry_t         entry_d [Depth];
  logic [DataWidth-1:0] data_q  [Depth];
  logic [DataWidth-1:0] data_d  [Depth];

  function automatic ptr_t ptr_inc(ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CntW'(Depth));
  assign head_o      = entry_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];

  // Order matters: kill, then pop, then push, so a push into the slot being
  // popped (full buffer) keeps its own live flag.
  always_comb begin
    entry_d  = entry_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (kill_i) begin
      for (int i = 0; i < Depth; i++) begin
        if (entry_q[i].addr == kill_addr_i) entry_d[i].live = 1'b0;
      end
    end
    if (pop_i) begin
      // Popped slots are marked dead so live alone qualifies a forward hit.
      entry_d[rd_ptr_q].live = 1'b0;
      rd_ptr_d               = ptr_inc(rd_ptr_q);
    end
    if (push_i) begin
      entry_d[wr_ptr_q].addr = push_addr_i;
      entry_d[wr_ptr_q].live = (push_addr_i != '0) &&
                               !(kill_i && (kill_addr_i == push_addr_i));
      data_d[wr_ptr_q]       = push_data_i;
      wr_ptr_d               = ptr_inc(wr_ptr_q);
    end
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest; a later match overwrites, so the youngest wins.
  always_comb begin
    int unsigned idx;
    idx          = 0;
    fwd_a_hit_o  = 1'b0;
    fwd_a_data_o = '0;
    fwd_b_hit_o  = 1'b0;
    fwd_b_data_o = '0;
    for (int unsigned k = 0; k < Depth; k++) begin
      idx = 32'(rd_ptr_q) + k;
      if (idx >= Depth) idx = idx - Depth;
      if (entry_q[ptr_t'(idx)].live) begin
        if ((raddr_a_i != '0) && (entry_q[ptr_t'(idx)].addr == raddr_a_i)) begin
          fwd_a_hit_o  = 1'b1;
          fwd_a_data_o = data_q[ptr_t'(idx)];
        end
        if ((raddr_b_i != '0) && (entry_q[ptr_t'(idx)].addr == raddr_b_i)) begin
          fwd_b_hit_o  = 1'b1;
          fwd_b_data_o = data_q[ptr_t'(idx)];
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        entry_q[i] <= '0;
        data_q[i]  <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      entry_q  <= entry_d;
      data_q   <= data_d;
    end
  end

endmodule

// File: rtl/ibex_rf_write_arbiter.sv
// Register-file write-port arbiter: execute writeback always wins, load
// writebacks bypass when nothing is pending, otherwise queue in order.
// Ports:
//   clk_i, rst_ni                         clock, async active-low reset
//   ex_we_i/ex_waddr_i/ex_wdata_i         execute writeback (never stalled)
//   lsu_valid_i/lsu_ready_o/lsu_waddr_i/lsu_wdata_i  load writeback handshake
//   rf_we_o/rf_waddr_o/rf_wdata_o         register file write port
//   raddr_{a,b}_i, fwd_{a,b}_hit_o/_data_o  forwarding of pending load data
//   busy_o                                pending buffer non-empty
module ibex_rf_write_arbiter
  import ibex_rf_write_arbiter_pkg::*;
#(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned Depth     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_we_i,
  input  logic [RfAddrW-1:0]   ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 lsu_valid_i,
  output logic                 lsu_ready_o,
  input  logic [RfAddrW-1:0]   lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 rf_we_o,
  output logic [RfAddrW-1:0]   rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  input  logic [RfAddrW-1:0]   raddr_a_i,
  input  logic [RfAddrW-1:0]   raddr_b_i,
  output logic                 fwd_a_hit_o,
  output logic                 fwd_b_hit_o,
  output logic [DataWidth-1:0] fwd_a_data_o,
  output logic [DataWidth-1:0] fwd_b_data_o,
  output logic                 busy_o
);

  logic                 fifo_empty;
  logic                 fifo_full;
  rf_wr_entry_t         head;
  logic [DataWidth-1:0] head_data;
  logic                 lsu_hs;
  logic                 bypass;
  logic                 push;
  logic                 pop;

  assign lsu_ready_o = ~fifo_full;
  assign lsu_hs      = lsu_valid_i & lsu_ready_o;
  assign pop         = ~ex_we_i & ~fifo_empty;
  assign bypass      = ~ex_we_i & fifo_empty & lsu_hs;
  // A load accepted while the port is taken (ex write or a pop) must queue
  // behind anything already pending to keep write order.
  assign push        = lsu_hs & ~bypass;
  assign busy_o      = ~fifo_empty;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    if (ex_we_i) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = ex_waddr_i;
      rf_wdata_o = ex_wdata_i;
    end else if (!fifo_empty) begin
      rf_we_o    = head.live;
      rf_waddr_o = head.addr;
      rf_wdata_o = head_data;
    end else if (lsu_hs && (lsu_waddr_i != '0)) begin
      rf_we_o    = 1'b1;
      rf_waddr_o = lsu_waddr_i;
      rf_wdata_o = lsu_wdata_i;
    end
  end

  ibex_rf_wr_fifo #(
    .DataWidth (DataWidth),
    .Depth     (Depth)
  ) u_fifo (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .push_i       (push),
    .push_addr_i  (lsu_waddr_i),
    .push_data_i  (lsu_wdata_i),
    .pop_i        (pop),
    .kill_i       (ex_we_i),
    .kill_addr_i  (ex_waddr_i),
    .empty_o      (fifo_empty),
    .full_o       (fifo_full),
    .head_o       (head),
    .head_data_o  (head_data),
    .raddr_a_i    (raddr_a_i),
    .raddr_b_i    (raddr_b_i),
    .fwd_a_hit_o  (fwd_a_hit_o),
    .fwd_a_data_o (fwd_a_data_o),
    .fwd_b_hit_o  (fwd_b_hit_o),
    .fwd_b_data_o (fwd_b_data_o)
  );

endmodule

// File: tb/tb_ibex_rf_write_arbiter.sv
// Directed bench for ibex_rf_write_arbiter (DataWidth=32, Depth=2).
module tb_ibex_rf_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_wdata;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_waddr;
  logic [31:0] lsu_wdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic        fwd_a_hit;
  logic        fwd_b_hit;
  logic [31:0] fwd_a_data;
  logic [31:0] fwd_b_data;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  ibex_rf_write_arbiter #(
    .DataWidth (32),
    .Depth     (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ex_we_i      (ex_we),
    .ex_waddr_i   (ex_waddr),
    .ex_wdata_i   (ex_wdata),
    .lsu_valid_i  (lsu_valid),
    .lsu_ready_o  (lsu_ready),
    .lsu_waddr_i  (lsu_waddr),
    .lsu_wdata_i  (lsu_wdata),
    .rf_we_o      (rf_we),
    .rf_waddr_o   (rf_waddr),
    .rf_wdata_o   (rf_wdata),
    .raddr_a_i    (raddr_a),
    .raddr_b_i    (raddr_b),
    .fwd_a_hit_o  (fwd_a_hit),
    .fwd_b_hit_o  (fwd_b_hit),
    .fwd_a_data_o (fwd_a_data),
    .fwd_b_data_o (fwd_b_data),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic ex_set(input logic we, input logic [4:0] a, input logic [31:0] d);
    ex_we    = we;
    ex_waddr = a;
    ex_wdata = d;
  endtask

  task automatic lsu_set(input logic v, input logic [4:0] a, input logic [31:0] d);
    lsu_valid = v;
    lsu_waddr = a;
    lsu_wdata = d;
  endtask

  initial begin
    rst_n   = 1'b0;
    raddr_a = '0;
    raddr_b = '0;
    ex_set(1'b0, 5'd0, 32'h0);
    lsu_set(1'b0, 5'd0, 32'h0);
    #12;
    check_eq("rst_rf_we", rf_we, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", lsu_ready, 1);
    check_eq("rst_fwd_a", fwd_a_hit, 0);
    check_eq("rst_fwd_b", fwd_b_hit, 0);
    check_eq("rst_waddr", rf_waddr, 0);
    check_eq("rst_wdata", rf_wdata, 0);
    rst_n = 1'b1;
    tick();

    // Idle bypass
    lsu_set(1'b1, 5'd5, 32'hA5A5);
    mid();
    check_eq("idle_we", rf_we, 1);
    check_eq("idle_waddr", rf_waddr, 5);
    check_eq("idle_wdata", rf_wdata, 32'hA5A5);
    tick();
    lsu_set(1'b0, 5'd0, 32'h0);
    mid();
    check_eq("idle_busy", busy, 0);
    check_eq("idle_we_after", rf_we, 0);
    tick();

    // Conflict: ex wins, load queued and forwarded
    ex_set(1'b1, 5'd3, 32'h11);
    lsu_set(1'b1, 5'd7, 32'h22);
    mid();
    check_eq("cf_c0_waddr", rf_waddr, 3);
    check_eq("cf_c0_wdata", rf_wdata, 32'h11);
    check_eq("cf_c0_ready", lsu_ready, 1);
    tick();
    ex_set(1'b0, 5'd0, 32'h0);
    lsu_set(1'b0, 5'd0, 32'h0);
    raddr_a = 5'd7;
    mid();
    check_eq("cf_fwd_hit", fwd_a_hit, 1);
    check_eq("cf_fwd_data", fwd_a_data, 32'h22);
    check_eq("cf_c1_we", rf_we, 1);
    check_eq("cf_c1_waddr", rf_waddr, 7);
    check_eq("cf_c1_wdata", rf_wdata, 32'h22);
    tick();
    mid();
    check_eq("cf_busy_end", busy, 0);
    check_eq("cf_fwd_end", fwd_a_hit, 0);
    raddr_a = '0;
    tick();

    // Full buffer
    ex_set(1'b1, 5'd1, 32'h1);
    lsu_set(1'b1, 5'd10, 32'hA);
    mid();
    check_eq("full_rdy0", lsu_ready, 1);
    tick();
    lsu_set(1'b1, 5'd11, 32'hB);
    mid();
    check_eq("full_rdy1", lsu_ready, 1);
    tick();
    lsu_set(1'b1, 5'd12, 32'hC);
    mid();
    check_eq("full_rdy2", lsu_ready, 0);
    check_eq("full_busy", busy, 1);
    tick();
    ex_set(1'b0, 5'd0, 32'h0);
    lsu_set(1'b0, 5'd0, 32'h0);
    mid();
    check_eq("full_pop0_waddr", rf_waddr, 10);
    check_eq("full_pop0_wdata", rf_wdata, 32'hA);
    check_eq("full_pop0_rdy", lsu_ready, 0);
    tick();
    mid();
    check_eq("full_pop1_waddr", rf_waddr, 11);
    check_eq("full_pop1_wdata", rf_wdata, 32'hB);
    check_eq("full_pop1_rdy", lsu_ready, 1);
    tick();
    mid();
    check_eq("full_end_we", rf_we, 0);
    check_eq("full_end_busy", busy, 0);
    tick();

    // Kill
    ex_set(1'b1, 5'd2, 32'h0);
    lsu_set(1'b1, 5'd9, 32'h33);
    tick();
    ex_set(1'b1, 5'd9, 32'h44);
    lsu_set(1'b0, 5'd0, 32'h0);
    raddr_a = 5'd9;
    mid();
    check_eq("kill_fwd_before", fwd_a_hit, 1);
    check_eq("kill_fwd_data", fwd_a_data, 32'h33);
    check_eq("kill_ex_wdata", rf_wdata, 32'h44);
    tick();
    ex_set(1'b0, 5'd0, 32'h0);
    mid();
    check_eq("kill_pop_we", rf_we, 0);
    check_eq("kill_fwd_after", fwd_a_hit, 0);
    check_eq("kill_pop_busy", busy, 1);
    tick();
    mid();
    check_eq("kill_end_busy", busy, 0);
    raddr_a = '0;
    tick();

    // Youngest match
    ex_set(1'b1, 5'd2, 32'h0);
    lsu_set(1'b1, 5'd4, 32'h1);
    tick();
    lsu_set(1'b1, 5'd4, 32'h2);
    tick();
    lsu_set(1'b0, 5'd0, 32'h0);
    raddr_b = 5'd4;
    mid();
    check_eq("yng_hit", fwd_b_hit, 1);
    check_eq("yng_data", fwd_b_data, 32'h2);
    tick();
    ex_set(1'b0, 5'd0, 32'h0);
    mid();
    check_eq("yng_pop0_waddr", rf_waddr, 4);
    check_eq("yng_pop0_wdata", rf_wdata, 32'h1);
    tick();
    mid();
    check_eq("yng_pop1_wdata", rf_wdata, 32'h2);
    check_eq("yng_pop1_fwd", fwd_b_data, 32'h2);
    tick();
    mid();
    check_eq("yng_end_hit", fwd_b_hit, 0);
    raddr_b = '0;
    tick();

    // Reset with two pending entries
    ex_set(1'b1, 5'd2, 32'h0);
    lsu_set(1'b1, 5'd13, 32'hD);
    tick();
    lsu_set(1'b1, 5'd14, 32'hE);
    tick();
    ex_set(1'b0, 5'd0, 32'h0);
    lsu_set(1'b0, 5'd0, 32'h0);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_ready", lsu_ready, 1);
    check_eq("mrst_we", rf_we, 0);
    mid();
    rst_n = 1'b1;
    tick();
    mid();
    check_eq("mrst_we_after", rf_we, 0);
    check_eq("mrst_busy_after", busy, 0);
    tick();

    // x0 loads and same-cycle kill of a pushed load
    lsu_set(1'b1, 5'd0, 32'h55);
    mid();
    check_eq("x0_bypass_we", rf_we, 0);
    tick();
    lsu_set(1'b0, 5'd0, 32'h0);
    mid();
    check_eq("x0_bypass_busy", busy, 0);
    tick();
    ex_set(1'b1, 5'd6, 32'h66);
    lsu_set(1'b1, 5'd6, 32'h77);
    mid();
    check_eq("samek_ex_wdata", rf_wdata, 32'h66);
    tick();
    ex_set(1'b0, 5'd0, 32'h0);
    lsu_set(1'b0, 5'd0, 32'h0);
    raddr_a = 5'd6;
    mid();
    check_eq("samek_busy", busy, 1);
    check_eq("samek_pop_we", rf_we, 0);
    check_eq("samek_fwd", fwd_a_hit, 0);
    tick();
    mid();
    check_eq("samek_end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
